// File: rtl/pc_gen.sv
// pc_gen: instruction fetch address generator with stall, deferred branch, flush and wrap.
// Optional misaligned-target redirect is built in when PC_MISALIGN_CHECK_EN is defined.
module pc_gen #(
  parameter int              ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int              INST_BYTES = 4,
  parameter logic [ADDR_W-1:0] EXC_VEC  = ADDR_W'(32'h0000_0020)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_target_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              branch_pend_o,
  output logic              misalign_o
);
  localparam logic [ADDR_W-1:0] INC = ADDR_W'(INST_BYTES);
  logic [ADDR_W-1:0] r_pc, r_pend_tgt, w_tgt, w_fix, w_next;
  logic              r_ce, r_pend, r_mis, w_load, w_bad;
  assign w_load = flush_i | (~stall_i & (branch_flag_i | r_pend));
  assign w_tgt  = flush_i ? new_pc_i : branch_flag_i ? branch_target_i : r_pend_tgt;
`ifdef PC_MISALIGN_CHECK_EN
  // a flush straight to the exception vector is never redirected again
  assign w_bad  = w_load & (|(w_tgt & (INC - 1'b1))) & ~(flush_i & (new_pc_i == EXC_VEC));
`else
  assign w_bad  = 1'b0;
`endif
  assign w_fix  = w_bad ? EXC_VEC : w_tgt;
  assign w_next = ~r_ce ? RESET_PC : w_load ? w_fix : stall_i ? r_pc : r_pc + INC;
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_ce       <= 1'b0;
      r_pc       <= RESET_PC;
      r_pend     <= 1'b0;
      r_pend_tgt <= '0;
      r_mis      <= 1'b0;
    end else begin
      r_ce  <= 1'b1;
      r_pc  <= w_next;
      r_mis <= r_ce & w_bad;
      r_pend <= r_ce & ~flush_i & stall_i & (branch_flag_i | r_pend);
      if (r_ce && !flush_i && stall_i && branch_flag_i) r_pend_tgt <= branch_target_i;
    end
  end
  assign pc            = r_pc;
  assign ce            = r_ce;
  assign branch_pend_o = r_pend;
  assign misalign_o    = r_mis;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen (default 32-bit and an 8-bit wrap instance).
module tb_pc_gen;
  typedef struct {
    logic [31:0] pc;
    bit          cpc;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;

`ifdef PC_MISALIGN_CHECK_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, stall, br, fl;
  logic [31:0] br_tgt, new_pc, pc;
  logic        ce, pend, mis;
  logic        rst2;
  logic        z1 = 1'b0;
  logic [7:0]  z8 = 8'h00;
  logic [7:0]  pc2;
  logic        ce2, pend2, mis2;
  exp_t        sb[$];
  int          tests = 0;
  int          fails = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall_i(stall), .branch_flag_i(br), .branch_target_i(br_tgt),
    .flush_i(fl), .new_pc_i(new_pc), .pc(pc), .ce(ce), .branch_pend_o(pend), .misalign_o(mis)
  );

  pc_gen #(.ADDR_W(8)) dut8 (
    .clk(clk), .rst(rst2), .stall_i(z1), .branch_flag_i(z1), .branch_target_i(z8),
    .flush_i(z1), .new_pc_i(z8), .pc(pc2), .ce(ce2), .branch_pend_o(pend2), .misalign_o(mis2)
  );

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    tests++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, o, e);
    end
  endtask

  // push the expectation for this edge, clock it, then pop and compare
  task automatic cyc(input string tag, input logic [31:0] p, input bit cpc,
                     input logic c, input logic pe, input logic m);
    exp_t e;
    sb.push_back('{pc: p, cpc: cpc, ce: c, pend: pe, mis: m});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk({tag, ".ce"}, 64'(ce), 64'(e.ce));
    chk({tag, ".pend"}, 64'(pend), 64'(e.pend));
    chk({tag, ".mis"}, 64'(mis), 64'(e.mis));
    if (e.cpc) chk({tag, ".pc"}, 64'(pc), 64'(e.pc));
  endtask

  initial begin
    rst = 1'b0; rst2 = 1'b0; stall = 1'b0; br = 1'b0; fl = 1'b0;
    br_tgt = '0; new_pc = '0;
    #2;
    cyc("rst0", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc("rst1", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rel", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("seq4", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("seq8", 32'h8, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("seqC", 32'hC, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("seq10", 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    // stalled branch deferred until release
    stall = 1'b1;
    cyc("stall1", 32'h10, 1'b1, 1'b1, 1'b0, 1'b0);
    br = 1'b1; br_tgt = 32'h100;
    cyc("stall2", 32'h10, 1'b1, 1'b1, 1'b1, 1'b0);
    br = 1'b0;
    cyc("stall3", 32'h10, 1'b1, 1'b1, 1'b1, 1'b0);
    stall = 1'b0;
    cyc("pendld", 32'h100, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("pend+4", 32'h104, 1'b1, 1'b1, 1'b0, 1'b0);
    // newer branch overwrites older during one stall
    stall = 1'b1; br = 1'b1; br_tgt = 32'h200;
    cyc("ovr1", 32'h104, 1'b1, 1'b1, 1'b1, 1'b0);
    br_tgt = 32'h300;
    cyc("ovr2", 32'h104, 1'b1, 1'b1, 1'b1, 1'b0);
    stall = 1'b0; br = 1'b0;
    cyc("ovrld", 32'h300, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("ovr+4", 32'h304, 1'b1, 1'b1, 1'b0, 1'b0);
    // live branch beats pending
    stall = 1'b1; br = 1'b1; br_tgt = 32'h400;
    cyc("live1", 32'h304, 1'b1, 1'b1, 1'b1, 1'b0);
    stall = 1'b0; br_tgt = 32'h500;
    cyc("live2", 32'h500, 1'b1, 1'b1, 1'b0, 1'b0);
    br = 1'b0;
    cyc("live+4", 32'h504, 1'b1, 1'b1, 1'b0, 1'b0);
    // flush beats stall, branch and pending
    stall = 1'b1; br = 1'b1; br_tgt = 32'h600;
    cyc("fpend", 32'h504, 1'b1, 1'b1, 1'b1, 1'b0);
    fl = 1'b1; new_pc = 32'h80; br_tgt = 32'h200;
    cyc("flush", 32'h80, 1'b1, 1'b1, 1'b0, 1'b0);
    fl = 1'b0; stall = 1'b0; br = 1'b0;
    cyc("flush+4", 32'h84, 1'b1, 1'b1, 1'b0, 1'b0);
    // misaligned branch target
    br = 1'b1; br_tgt = 32'h102;
    cyc("mis", MIS ? 32'h20 : 32'h102, 1'b1, 1'b1, 1'b0, MIS);
    br = 1'b0;
    cyc("mis+4", MIS ? 32'h24 : 32'h106, 1'b1, 1'b1, 1'b0, 1'b0);
    // reset while a branch is pending; inputs ignored while ce is low
    stall = 1'b1; br = 1'b1; br_tgt = 32'h700;
    cyc("rpend", MIS ? 32'h24 : 32'h106, 1'b1, 1'b1, 1'b1, 1'b0);
    rst = 1'b0; br_tgt = 32'h900; fl = 1'b1; new_pc = 32'h880;
    cyc("rmid", 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    cyc("rrel", 32'h0, 1'b1, 1'b1, 1'b0, 1'b0);
    stall = 1'b0; br = 1'b0; fl = 1'b0;
    cyc("rrel+4", 32'h4, 1'b1, 1'b1, 1'b0, 1'b0);
    // 8-bit wrap on the second instance
    rst2 = 1'b0;
    @(posedge clk); #1;
    rst2 = 1'b1;
    @(posedge clk); #1;
    chk("w8.start", 64'(pc2), 64'h0);
    for (int i = 0; i < 63; i++) begin
      @(posedge clk); #1;
    end
    chk("w8.FC", 64'(pc2), 64'hFC);
    @(posedge clk); #1;
    chk("w8.wrap", 64'(pc2), 64'h00);
    chk("w8.mis", 64'(mis2), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
